atm_session_timer: RTL and testbench

Session-timeout controller for the ATM/vending front end. It consumes the 4 Hz single-cycle tick from the slow-clock divider and counts whole seconds of user inactivity. It raises a warning phase with a 2 Hz blink, then issues a one-cycle timeout pulse to the main transaction FSM. It also drives a seconds-remaining value for the display path.

---
 rtl/atm_session_timer.sv | 90 +++++++++
 tb/tb_atm_session_timer.sv | 120 ++++++++++++
 2 files changed

// File: rtl/atm_session_timer.sv
// atm_session_timer: counts whole seconds of inactivity from a slow tick, then blinks a warning
// and fires a single-cycle timeout pulse; reloads on session start or user activity.
module atm_session_timer #(
    parameter int TIMEOUT_S   = 30,
    parameter int WARN_S      = 10,
    parameter int TICKS_PER_S = 4
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       tick_4hz,
    input  logic       session_start,
    input  logic       activity,
    input  logic       session_end,
    output logic [1:0] state,
    output logic [7:0] secs_left,
    output logic       session_active,
    output logic       warn_blink,
    output logic       timeout_pulse
);
    typedef enum logic [1:0] {IDLE = 2'b00, ACTIVE = 2'b01, WARN = 2'b10, EXPIRED = 2'b11} state_t;

    localparam int QW = TICKS_PER_S > 1 ? $clog2(TICKS_PER_S) : 1;
    localparam logic [QW-1:0] QMAX    = QW'(TICKS_PER_S - 1);
    localparam logic [7:0]    RELOAD  = 8'(TIMEOUT_S);
    localparam logic [7:0]    WARN_TH = 8'(WARN_S);

    state_t        state_q;
    logic [7:0]    secs_q;
    logic [QW-1:0] qcnt_q;
    logic          active_q, blink_q, pulse_q;
    logic [7:0]    secs_dec;
    logic          live;

    assign live     = state_q == ACTIVE || state_q == WARN;
    // saturating decrement so the seconds count can never wrap
    assign secs_dec = secs_q - 8'(secs_q != 8'd0);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            secs_q   <= 8'd0;
            qcnt_q   <= '0;
            active_q <= 1'b0;
            blink_q  <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            if (session_end) begin
                state_q  <= IDLE;
                secs_q   <= 8'd0;
                qcnt_q   <= '0;
                active_q <= 1'b0;
                blink_q  <= 1'b0;
            end else if (session_start || (activity && live)) begin
                state_q  <= ACTIVE;
                secs_q   <= RELOAD;
                qcnt_q   <= '0;
                active_q <= 1'b1;
                blink_q  <= 1'b0;
            end else if (tick_4hz && live) begin
                if (qcnt_q != QMAX) begin
                    qcnt_q <= qcnt_q + 1'b1;
                    if (state_q == WARN) blink_q <= !blink_q;
                end else if (secs_dec == 8'd0) begin
                    state_q  <= EXPIRED;
                    secs_q   <= 8'd0;
                    qcnt_q   <= '0;
                    active_q <= 1'b0;
                    blink_q  <= 1'b0;
                    pulse_q  <= 1'b1;
                end else begin
                    qcnt_q <= '0;
                    secs_q <= secs_dec;
                    if (state_q == ACTIVE && secs_dec <= WARN_TH) begin
                        state_q <= WARN;
                        blink_q <= 1'b1;
                    end else if (state_q == WARN) begin
                        blink_q <= !blink_q;
                    end
                end
            end
        end
    end

    assign state          = state_q;
    assign secs_left      = secs_q;
    assign session_active = active_q;
    assign warn_blink     = blink_q;
    assign timeout_pulse  = pulse_q;
endmodule

// File: tb/tb_atm_session_timer.sv
// tb_atm_session_timer: directed vectors for the session timer with TIMEOUT_S=5, WARN_S=2, TICKS_PER_S=4.
module tb_atm_session_timer;
    logic       clk_in = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_4hz = 1'b0, session_start = 1'b0, activity = 1'b0, session_end = 1'b0;
    logic [1:0] state;
    logic [7:0] secs_left;
    logic       session_active, warn_blink, timeout_pulse;
    int         nvec = 0, nmis = 0, pcnt = 0;

    atm_session_timer #(.TIMEOUT_S(5), .WARN_S(2), .TICKS_PER_S(4)) dut (
        .clk_in(clk_in), .rst_n(rst_n), .tick_4hz(tick_4hz), .session_start(session_start),
        .activity(activity), .session_end(session_end), .state(state), .secs_left(secs_left),
        .session_active(session_active), .warn_blink(warn_blink), .timeout_pulse(timeout_pulse)
    );

    always #5 clk_in = !clk_in;

    always @(posedge clk_in) if (timeout_pulse) pcnt <= pcnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic t, input logic s, input logic a, input logic e);
        @(negedge clk_in);
        tick_4hz = t; session_start = s; activity = a; session_end = e;
        @(posedge clk_in);
        #1;
        tick_4hz = 0; session_start = 0; activity = 0; session_end = 0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            step(1, 0, 0, 0);
            repeat (7) step(0, 0, 0, 0);
        end
    endtask

    task automatic outs(input string tag, input int st, input int sl, input int act, input int bl);
        check({tag, ".state"}, 32'(state), 32'(st));
        check({tag, ".secs"}, 32'(secs_left), 32'(sl));
        check({tag, ".active"}, 32'(session_active), 32'(act));
        check({tag, ".blink"}, 32'(warn_blink), 32'(bl));
    endtask

    initial begin
        #12;
        outs("reset", 0, 0, 0, 0);
        check("reset.pulse", 32'(timeout_pulse), 0);
        @(negedge clk_in) rst_n = 1'b1;
        ticks(4);
        step(0, 0, 1, 0);
        outs("idle_ignore", 0, 0, 0, 0);
        // countdown through warning to expiry
        step(0, 1, 0, 0);
        outs("start", 1, 5, 1, 0);
        ticks(4);  outs("t4", 1, 4, 1, 0);
        ticks(4);  outs("t8", 1, 3, 1, 0);
        ticks(3);  outs("t11", 1, 3, 1, 0);
        ticks(1);  outs("t12", 2, 2, 1, 1);
        ticks(1);  outs("t13", 2, 2, 1, 0);
        ticks(1);  outs("t14", 2, 2, 1, 1);
        ticks(1);  outs("t15", 2, 2, 1, 0);
        ticks(1);  outs("t16", 2, 1, 1, 1);
        ticks(3);  outs("t19", 2, 1, 1, 0);
        step(1, 0, 0, 0);
        outs("t20", 3, 0, 0, 0);
        check("t20.pulse", 32'(timeout_pulse), 1);
        step(0, 0, 0, 0);
        check("t20.pulse_off", 32'(timeout_pulse), 0);
        ticks(8);  outs("exp_ticks", 3, 0, 0, 0);
        step(0, 0, 1, 0);
        outs("exp_act", 3, 0, 0, 0);
        check("pulse_count1", 32'(pcnt), 1);
        // restart from expired, then activity reload in warning
        step(0, 1, 0, 0);
        outs("restart", 1, 5, 1, 0);
        check("restart.pulse", 32'(timeout_pulse), 0);
        ticks(14); outs("r14", 2, 2, 1, 1);
        step(0, 0, 1, 0);
        outs("reload", 1, 5, 1, 0);
        ticks(3);  outs("reload3", 1, 5, 1, 0);
        ticks(1);  outs("reload4", 1, 4, 1, 0);
        // session_end beats session_start and a coincident expiring tick
        step(0, 1, 0, 1);
        outs("end_prio", 0, 0, 0, 0);
        step(0, 1, 0, 0);
        ticks(19); outs("s19", 2, 1, 1, 0);
        step(1, 0, 0, 1);
        outs("end_t20", 0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("end_t20.pulse", 32'(timeout_pulse), 0);
        check("pulse_count2", 32'(pcnt), 1);
        // activity on a decrementing tick wins
        step(0, 1, 0, 0);
        ticks(3);
        step(1, 0, 1, 0);
        outs("act_tick", 1, 5, 1, 0);
        repeat (7) step(0, 0, 0, 0);
        ticks(3);  outs("act_tick3", 1, 5, 1, 0);
        ticks(1);  outs("act_tick4", 1, 4, 1, 0);
        // asynchronous reset mid-warning
        ticks(8);  outs("pre_rst", 2, 2, 1, 1);
        #3 rst_n = 1'b0;
        #1;
        outs("async_rst", 0, 0, 0, 0);
        @(negedge clk_in) rst_n = 1'b1;
        ticks(8);  outs("post_rst", 0, 0, 0, 0);
        step(0, 1, 0, 0);
        outs("post_start", 1, 5, 1, 0);
        check("pulse_count3", 32'(pcnt), 1);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
